// File: rtl/instruction_fetch.sv
// instruction_fetch: front-end fetch stage feeding the instruction decoder.
// Each 16-bit instruction word is assembled from two byte reads on the 8-bit
// memory bus. The low byte is read first, at the word address.
// The word is then presented to the decoder with a valid/ready handshake.
// Execute can redirect the fetch at any time with jump/jump_addr.
//
// Build option: define PREFETCH_EN to add a one-word prefetch buffer. The bus
// keeps fetching the next word while the decoder holds the current one.
//
// Handshakes (both interfaces):
//   A producer raises valid (mem_rd / word_valid) and keeps it and its payload
//   (mem_addr / word, pc) stable until the consumer's ready is seen high on a
//   rising edge. The transfer happens on that edge. A ready seen without valid
//   has no effect. jump and reset override both interfaces on any edge: the
//   bus read in flight is abandoned and the presented word is withdrawn.

module instruction_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data_in,
  input  logic        mem_ready,
  output logic [15:0] word,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [15:0] pc,
  input  logic        jump,
  input  logic [15:0] jump_addr,
  output logic [1:0]  dbg_state
);

  // FETCH_LO/FETCH_HI: reading a byte of the word at r_fetch_pc.
  // HOLD: the bus is idle because there is nowhere to put another word.
  typedef enum logic [1:0] {
    FETCH_LO = 2'd0,
    FETCH_HI = 2'd1,
    HOLD     = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_fetch_pc;   // address of the word being read from the bus
  logic [7:0]  r_lo;         // low byte of the word being read
  logic [15:0] r_word;
  logic [15:0] r_pc;
  logic        r_valid;

  logic        w_accept;
  logic        w_lo_done;
  logic        w_hi_done;
  logic        w_buf_valid;
  logic        w_room;
  logic [15:0] w_new_word;
  logic [1:0]  w_occ_next;

`ifdef PREFETCH_EN
  // The output register plus one buffered word.
  localparam logic [1:0] SLOTS = 2'd2;
  logic [15:0] r_buf_word;
  logic [15:0] r_buf_pc;
  logic        r_buf_valid;
  assign w_buf_valid = r_buf_valid;
`else
  // Only the output register.
  localparam logic [1:0] SLOTS = 2'd1;
  assign w_buf_valid = 1'b0;
`endif

  assign w_accept   = r_valid & word_ready;
  assign w_lo_done  = (r_state == FETCH_LO) & mem_ready;
  assign w_hi_done  = (r_state == FETCH_HI) & mem_ready;
  assign w_new_word = {mem_data_in, r_lo};

  // Count the words held after this edge. The bus keeps running while there is room.
  assign w_occ_next = {1'b0, r_valid} + {1'b0, w_buf_valid}
                    + {1'b0, w_hi_done} - {1'b0, w_accept};
  assign w_room     = (w_occ_next < SLOTS);

  assign word       = r_word;
  assign word_valid = r_valid;
  assign pc         = r_pc;
  assign dbg_state  = r_state;

  // Bus request: read the low byte at fetch_pc, then the high byte at fetch_pc+1 (wraps).
  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = r_fetch_pc;
    if (!reset && (r_state == FETCH_LO || r_state == FETCH_HI)) begin
      mem_rd = 1'b1;
    end
    if (r_state == FETCH_HI) begin
      mem_addr = r_fetch_pc + 16'd1;
    end
  end

  // Next fetch state, computed without jump and reset; both are applied in the state register.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH_LO: begin
        if (mem_ready) begin
          w_state_next = FETCH_HI;
        end
      end
      FETCH_HI: begin
        if (mem_ready) begin
          w_state_next = w_room ? FETCH_LO : HOLD;
        end
      end
      HOLD: begin
        if (w_room) begin
          w_state_next = FETCH_LO;
        end
      end
      default: w_state_next = FETCH_LO;
    endcase
  end

  // Fetch state, fetch address and low-byte latch; jump restarts at jump_addr and drops any partial word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FETCH_LO;
      r_fetch_pc <= RESET_PC;
      r_lo       <= '0;
    end else if (jump) begin
      r_state    <= FETCH_LO;
      r_fetch_pc <= jump_addr;
    end else begin
      r_state <= w_state_next;
      if (w_lo_done) begin
        r_lo <= mem_data_in;
      end
      if (w_hi_done) begin
        r_fetch_pc <= r_fetch_pc + 16'd2;
      end
    end
  end

  // Presented word, its pc and (with prefetch) the buffered next word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word  <= '0;
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
`ifdef PREFETCH_EN
      r_buf_valid <= 1'b0;
      r_buf_word  <= '0;
      r_buf_pc    <= RESET_PC;
`endif
    end else if (jump) begin
      // A word accepted on this same edge still counts as consumed.
      r_valid <= 1'b0;
      r_pc    <= jump_addr;
`ifdef PREFETCH_EN
      r_buf_valid <= 1'b0;
`endif
    end else if (w_accept) begin
`ifdef PREFETCH_EN
      if (r_buf_valid) begin
        r_word      <= r_buf_word;
        r_pc        <= r_buf_pc;
        r_valid     <= 1'b1;
        r_buf_valid <= w_hi_done;
        if (w_hi_done) begin
          r_buf_word <= w_new_word;
          r_buf_pc   <= r_fetch_pc;
        end
      end else if (w_hi_done) begin
        r_word  <= w_new_word;
        r_pc    <= r_fetch_pc;
        r_valid <= 1'b1;
      end else begin
        r_valid <= 1'b0;
        r_pc    <= r_pc + 16'd2;
      end
`else
      r_valid <= 1'b0;
      r_pc    <= r_pc + 16'd2;
`endif
    end else if (w_hi_done) begin
      if (!r_valid) begin
        r_word  <= w_new_word;
        r_pc    <= r_fetch_pc;
        r_valid <= 1'b1;
      end
`ifdef PREFETCH_EN
      else begin
        r_buf_word  <= w_new_word;
        r_buf_pc    <= r_fetch_pc;
        r_buf_valid <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scenarios followed by randomized traffic.
// The expected values come from a byte-stream view of the fetch stage:
//  - the bus reads consecutive byte addresses from the start address;
//  - the decoder sees words {mem[a+1], mem[a]} at a, a+2, a+4, ...;
//  - reset restarts both streams at RESET_PC, and jump restarts them at jump_addr.

module tb_instruction_fetch;

  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk;
  logic        reset;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data_in;
  logic        mem_ready;
  logic [15:0] word;
  logic        word_valid;
  logic        word_ready;
  logic [15:0] pc;
  logic        jump;
  logic [15:0] jump_addr;
  logic [1:0]  dbg_state;

  // Second instance with RESET_PC at the top of the address space.
  logic [15:0] ff_mem_addr;
  logic        ff_mem_rd;
  logic [7:0]  ff_mem_data_in;
  logic [15:0] ff_word;
  logic        ff_word_valid;
  logic [15:0] ff_pc;
  logic [1:0]  ff_dbg_state;

  logic [7:0]  mem [0:65535];

  int          n_checks;
  int          n_errors;
  int          n_accepts;
  logic        model_ok;
  logic        hold_pend;
  logic [15:0] rd_exp;
  logic [31:0] exp_q[$];

  instruction_fetch #(.RESET_PC(RST_PC)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_data_in (mem_data_in),
    .mem_ready   (mem_ready),
    .word        (word),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .pc          (pc),
    .jump        (jump),
    .jump_addr   (jump_addr),
    .dbg_state   (dbg_state)
  );

  instruction_fetch #(.RESET_PC(16'hFFFF)) u_dut_ff (
    .clk         (clk),
    .reset       (reset),
    .mem_addr    (ff_mem_addr),
    .mem_rd      (ff_mem_rd),
    .mem_data_in (ff_mem_data_in),
    .mem_ready   (mem_ready),
    .word        (ff_word),
    .word_valid  (ff_word_valid),
    .word_ready  (word_ready),
    .pc          (ff_pc),
    .jump        (jump),
    .jump_addr   (jump_addr),
    .dbg_state   (ff_dbg_state)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_entry(input logic [15:0] a);
    logic [15:0] a1;
    a1 = a + 16'd1;
    return {a, mem[a1], mem[a]};
  endfunction

  task automatic restart_model(input logic [15:0] a);
    rd_exp = a;
    exp_q.delete();
    exp_q.push_back(exp_entry(a));
  endtask

  task automatic set_in(input logic rst, input logic jmp, input logic [15:0] jaddr,
                        input logic mrdy, input logic wrdy);
    reset      = rst;
    jump       = jmp;
    jump_addr  = jaddr;
    mem_ready  = mrdy;
    word_ready = wrdy;
  endtask

  // One clock: called at a falling edge with inputs set, returns at the next falling edge.
  task automatic tick();
    logic        p_rd, p_ready, p_valid, p_wready, p_jump, p_reset;
    logic [15:0] p_word, p_pc, p_jaddr;
    logic [31:0] e;
    #1;
    mem_data_in    = mem_rd    ? mem[mem_addr]    : 8'($urandom);
    ff_mem_data_in = ff_mem_rd ? mem[ff_mem_addr] : 8'($urandom);
    #1;
    if (model_ok) begin
      if (reset) begin
        check("rd_in_reset", 32'(mem_rd), 32'd0);
      end else begin
        if (hold_pend) check("rd_held", 32'(mem_rd), 32'd1);
        if (mem_rd) check("rd_addr", 32'(mem_addr), 32'(rd_exp));
`ifndef PREFETCH_EN
        if (word_valid) check("rd_in_hold", 32'(mem_rd), 32'd0);
`endif
        if (word_valid && word_ready) begin
          e = exp_q.pop_front();
          check("acc_pc", 32'(pc), 32'(e[31:16]));
          check("acc_word", 32'(word), 32'(e[15:0]));
          n_accepts++;
          exp_q.push_back(exp_entry(e[31:16] + 16'd2));
        end
      end
    end
    p_rd = mem_rd; p_ready = mem_ready; p_valid = word_valid; p_wready = word_ready;
    p_jump = jump; p_reset = reset; p_word = word; p_pc = pc; p_jaddr = jump_addr;
    @(posedge clk);
    if (p_reset) begin
      restart_model(RST_PC);
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (p_jump) restart_model(p_jaddr);
      else if (p_rd && p_ready) rd_exp = rd_exp + 16'd1;
    end
    hold_pend = model_ok && !p_reset && !p_jump && p_rd && !p_ready;
    @(negedge clk);
    if (model_ok) begin
      if (p_reset) begin
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_pc", 32'(pc), 32'(RST_PC));
        check("rst_word", 32'(word), 32'd0);
      end else if (p_jump) begin
        check("jmp_valid", 32'(word_valid), 32'd0);
        check("jmp_pc", 32'(pc), 32'(p_jaddr));
      end else if (p_valid && !p_wready) begin
        check("stall_valid", 32'(word_valid), 32'd1);
        check("stall_word", 32'(word), 32'(p_word));
        check("stall_pc", 32'(pc), 32'(p_pc));
      end
    end
  endtask

  task automatic wait_valid(input int max_cycles);
    int n;
    n = 0;
    while (!word_valid && n < max_cycles) begin
      tick();
      n++;
    end
    check("wait_valid", 32'(word_valid), 32'd1);
  endtask

  initial begin
    logic [31:0] e;
    int          a0;
    n_checks = 0; n_errors = 0; n_accepts = 0;
    model_ok = 1'b0; hold_pend = 1'b0; rd_exp = RST_PC;
    mem_data_in = '0; ff_mem_data_in = '0;
    set_in(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h34;
    mem[1] = 8'h12;
    @(negedge clk);

    // Reset, then first word with mem_ready high. Counting the last edge with
    // reset high, word_valid is set by the third edge.
    tick(); tick();
    set_in(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    tick();
    check("lat_edge1_valid", 32'(word_valid), 32'd0);
    tick();
    check("lat_edge2_valid", 32'(word_valid), 32'd1);
    check("first_word", 32'(word), 32'h1234);
    check("first_pc", 32'(pc), 32'h0000);

    // Decoder stalls for 10 cycles.
    repeat (10) tick();
    check("stall_end_word", 32'(word), 32'h1234);
    check("stall_end_pc", 32'(pc), 32'h0000);
    set_in(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    tick();

    // Next word at pc 2: the low byte completes, then the high byte waits for 4 cycles.
    set_in(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    tick();
`ifndef PREFETCH_EN
    check("hi_addr", 32'(mem_addr), 32'h0003);
`endif
    set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hi_wait_rd", 32'(mem_rd), 32'd1);
`ifndef PREFETCH_EN
      check("hi_wait_addr", 32'(mem_addr), 32'h0003);
      check("hi_wait_valid", 32'(word_valid), 32'd0);
`endif
    end

    // Jump to 0100 while mem_ready is high.
    set_in(1'b0, 1'b1, 16'h0100, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("jmp_bus_addr", 32'(mem_addr), 32'h0100);
    wait_valid(20);
    e = exp_entry(16'h0100);
    check("jmp_word", 32'(word), 32'(e[15:0]));
    set_in(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    tick();

    // Word at FFFF takes its high byte from 0000. After accept, pc is 0001.
    set_in(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    wait_valid(20);
    e = exp_entry(16'hFFFF);
    check("wrap_pc", 32'(pc), 32'hFFFF);
    check("wrap_word", 32'(word), 32'(e[15:0]));
    set_in(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    tick();
    check("wrap_next_pc", 32'(pc), 32'h0001);

    // Instance with RESET_PC = FFFF.
    set_in(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("ff_lo_addr", 32'(ff_mem_addr), 32'hFFFF);
    tick();
    check("ff_hi_addr", 32'(ff_mem_addr), 32'h0000);
    tick();
    check("ff_valid", 32'(ff_word_valid), 32'd1);
    check("ff_pc", 32'(ff_pc), 32'hFFFF);
    check("ff_word", 32'(ff_word), {16'h0000, mem[0], mem[65535]});
    set_in(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    tick();
    check("ff_next_pc", 32'(ff_pc), 32'h0001);

    // Streaming with both readies high: count accepts over 12 edges after reset.
    set_in(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
    tick();
    set_in(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    a0 = n_accepts;
    repeat (12) tick();
`ifdef PREFETCH_EN
    check("stream_words", 32'(n_accepts - a0), 32'd5);
`else
    check("stream_words", 32'(n_accepts - a0), 32'd4);
`endif
    set_in(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
    tick();
    check("midstream_rst_valid", 32'(word_valid), 32'd0);
    check("midstream_rst_pc", 32'(pc), 32'(RST_PC));

    // Randomized traffic.
    a0 = n_accepts;
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] ja;
      ja = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ja = 16'hFFF0 | 16'($urandom_range(0, 15));
      set_in(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0), ja,
             ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      tick();
    end
    check("random_progress", 32'(n_accepts - a0 >= 100), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
